// File: rtl/dcache_pkg.sv
// Shared data-cache constants and the MSHR entry-state type.
package dcache_pkg;

    localparam int unsigned DCACHE_INDEX_SIZE = 4;
    localparam int unsigned DCACHE_TAG_SIZE   = 54;
    localparam int unsigned DCACHE_BLOCK_SIZE = 64;
    localparam int unsigned MEM_TAG_SIZE      = 4;

    typedef enum logic [1:0] {
        EntryInvalid,
        EntryPending,
        EntryWaiting
    } mshr_state_e;

endpackage

// File: rtl/mshr_lowest_sel.sv
// One-hot select of the lowest set bit of a request vector.
module mshr_lowest_sel #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] gnt_o
);

    // Two's-complement trick isolates the least-significant set bit.
    assign gnt_o = req_i & (~req_i + Width'(1));

endmodule

// File: rtl/dcache_mshr.sv
// Miss-status holding registers for data-cache load misses: allocate, merge,
// issue to memory, and write the returning block back as a one-cycle fill.
module dcache_mshr
    import dcache_pkg::*;
#(
    parameter int unsigned MSHR_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         miss_valid,
    input  logic [DCACHE_INDEX_SIZE-1:0] miss_index,
    input  logic [DCACHE_TAG_SIZE-1:0]   miss_tag,
    output logic                         miss_ready,
    output logic                         miss_merged,
    output logic                         mem_req_valid,
    output logic [63:0]                  mem_req_addr,
    input  logic [MEM_TAG_SIZE-1:0]      mem_response,
    input  logic [MEM_TAG_SIZE-1:0]      mem_tag,
    input  logic [DCACHE_BLOCK_SIZE-1:0] load_data_in,
    output logic                         fill_valid,
    output logic [DCACHE_INDEX_SIZE-1:0] fill_index,
    output logic [DCACHE_TAG_SIZE-1:0]   fill_tag,
    output logic [DCACHE_BLOCK_SIZE-1:0] fill_data,
    output logic                         mshr_full,
    output logic                         mshr_empty
);

    mshr_state_e                  state_q [MSHR_DEPTH];
    mshr_state_e                  state_d [MSHR_DEPTH];
    logic [DCACHE_INDEX_SIZE-1:0] index_q [MSHR_DEPTH];
    logic [DCACHE_INDEX_SIZE-1:0] index_d [MSHR_DEPTH];
    logic [DCACHE_TAG_SIZE-1:0]   tag_q   [MSHR_DEPTH];
    logic [DCACHE_TAG_SIZE-1:0]   tag_d   [MSHR_DEPTH];
    logic [MEM_TAG_SIZE-1:0]      rsp_q   [MSHR_DEPTH];
    logic [MEM_TAG_SIZE-1:0]      rsp_d   [MSHR_DEPTH];

    logic                         fill_valid_q, fill_valid_d;
    logic [DCACHE_INDEX_SIZE-1:0] fill_index_q, fill_index_d;
    logic [DCACHE_TAG_SIZE-1:0]   fill_tag_q, fill_tag_d;
    logic [DCACHE_BLOCK_SIZE-1:0] fill_data_q, fill_data_d;

    logic [MSHR_DEPTH-1:0] invalid_vec, pending_vec, hit_vec, ret_vec;
    logic [MSHR_DEPTH-1:0] alloc_oh, issue_oh, ret_oh;
    logic                  alloc_en, accept_en;

    always_comb begin
        invalid_vec = '0;
        pending_vec = '0;
        hit_vec     = '0;
        ret_vec     = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            invalid_vec[i] = (state_q[i] == EntryInvalid);
            pending_vec[i] = (state_q[i] == EntryPending);
            hit_vec[i]     = (state_q[i] != EntryInvalid) && (index_q[i] == miss_index)
                             && (tag_q[i] == miss_tag);
            // Only registered tags can match, so a same-cycle acceptance never does.
            ret_vec[i]     = (state_q[i] == EntryWaiting) && (mem_tag != '0)
                             && (rsp_q[i] == mem_tag);
        end
    end

    mshr_lowest_sel #(.Width(MSHR_DEPTH)) u_alloc_sel (.req_i(invalid_vec), .gnt_o(alloc_oh));
    mshr_lowest_sel #(.Width(MSHR_DEPTH)) u_issue_sel (.req_i(pending_vec), .gnt_o(issue_oh));
    mshr_lowest_sel #(.Width(MSHR_DEPTH)) u_ret_sel   (.req_i(ret_vec),     .gnt_o(ret_oh));

    assign mshr_empty    = &invalid_vec;
    assign mshr_full     = ~|invalid_vec;
    assign miss_ready    = ~mshr_full;
    assign miss_merged   = miss_valid & (|hit_vec);
    assign alloc_en      = miss_valid & ~(|hit_vec) & miss_ready;
    assign mem_req_valid = |pending_vec;
    assign accept_en     = mem_req_valid & (mem_response != '0);

    always_comb begin
        mem_req_addr = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (issue_oh[i]) begin
                mem_req_addr = {3'b000, tag_q[i], index_q[i], 3'b000};
            end
        end
    end

    // Allocation, acceptance and return each target an entry in a distinct state.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        tag_d   = tag_q;
        rsp_d   = rsp_q;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (ret_oh[i]) begin
                state_d[i] = EntryInvalid;
            end else if (accept_en && issue_oh[i]) begin
                state_d[i] = EntryWaiting;
                rsp_d[i]   = mem_response;
            end else if (alloc_en && alloc_oh[i]) begin
                state_d[i] = EntryPending;
                index_d[i] = miss_index;
                tag_d[i]   = miss_tag;
            end
        end
    end

    always_comb begin
        fill_valid_d = |ret_oh;
        fill_index_d = fill_index_q;
        fill_tag_d   = fill_tag_q;
        fill_data_d  = fill_data_q;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (ret_oh[i]) begin
                fill_index_d = index_q[i];
                fill_tag_d   = tag_q[i];
                fill_data_d  = load_data_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                state_q[i] <= EntryInvalid;
                index_q[i] <= '0;
                tag_q[i]   <= '0;
                rsp_q[i]   <= '0;
            end
            fill_valid_q <= 1'b0;
            fill_index_q <= '0;
            fill_tag_q   <= '0;
            fill_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            tag_q        <= tag_d;
            rsp_q        <= rsp_d;
            fill_valid_q <= fill_valid_d;
            fill_index_q <= fill_index_d;
            fill_tag_q   <= fill_tag_d;
            fill_data_q  <= fill_data_d;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_index = fill_index_q;
    assign fill_tag   = fill_tag_q;
    assign fill_data  = fill_data_q;

endmodule

// File: tb/tb_dcache_mshr.sv
// Directed scenario bench for dcache_mshr with hand-computed expectations.
module tb_dcache_mshr;
    import dcache_pkg::*;

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    logic                         miss_valid;
    logic [DCACHE_INDEX_SIZE-1:0] miss_index;
    logic [DCACHE_TAG_SIZE-1:0]   miss_tag;
    logic                         miss_ready;
    logic                         miss_merged;
    logic                         mem_req_valid;
    logic [63:0]                  mem_req_addr;
    logic [3:0]                   mem_response;
    logic [3:0]                   mem_tag;
    logic [DCACHE_BLOCK_SIZE-1:0] load_data_in;
    logic                         fill_valid;
    logic [DCACHE_INDEX_SIZE-1:0] fill_index;
    logic [DCACHE_TAG_SIZE-1:0]   fill_tag;
    logic [DCACHE_BLOCK_SIZE-1:0] fill_data;
    logic                         mshr_full;
    logic                         mshr_empty;

    int errors = 0;
    int checks = 0;

    dcache_mshr #(.MSHR_DEPTH(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .miss_valid   (miss_valid),
        .miss_index   (miss_index),
        .miss_tag     (miss_tag),
        .miss_ready   (miss_ready),
        .miss_merged  (miss_merged),
        .mem_req_valid(mem_req_valid),
        .mem_req_addr (mem_req_addr),
        .mem_response (mem_response),
        .mem_tag      (mem_tag),
        .load_data_in (load_data_in),
        .fill_valid   (fill_valid),
        .fill_index   (fill_index),
        .fill_tag     (fill_tag),
        .fill_data    (fill_data),
        .mshr_full    (mshr_full),
        .mshr_empty   (mshr_empty)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        miss_valid   = 1'b0;
        miss_index   = '0;
        miss_tag     = '0;
        mem_response = '0;
        mem_tag      = '0;
        load_data_in = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        #3;
        checks++;
        if ({fill_valid, mem_req_valid, mshr_empty, mshr_full, miss_ready} !== 5'b00101) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00101",
                     {fill_valid, mem_req_valid, mshr_empty, mshr_full, miss_ready});
        end
        checks++;
        if ({fill_index, fill_tag, fill_data} !== '0) begin
            errors++;
            $display("FAIL reset_fill_bus: got %h/%h/%h want 0", fill_index, fill_tag, fill_data);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_fill();
        apply_reset();
        miss_valid = 1'b1; miss_index = 4'd2; miss_tag = 54'd1;
        #1;
        checks++;
        if ({miss_ready, miss_merged, mem_req_valid} !== 3'b100) begin
            errors++;
            $display("FAIL basic_alloc_cycle: got %b want 100", {miss_ready, miss_merged, mem_req_valid});
        end
        tick();
        miss_valid = 1'b0; mem_response = 4'd1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== {3'b000, 54'd1, 4'd2, 3'b000}) begin
            errors++;
            $display("FAIL basic_issue: got v=%b addr=%h want v=1 addr=%h", mem_req_valid,
                     mem_req_addr, {3'b000, 54'd1, 4'd2, 3'b000});
        end
        tick();
        mem_response = '0; mem_tag = 4'd1; load_data_in = 64'hffff;
        #1;
        checks++;
        if ({mem_req_valid, mshr_empty, fill_valid} !== 3'b000) begin
            errors++;
            $display("FAIL basic_waiting: got %b want 000", {mem_req_valid, mshr_empty, fill_valid});
        end
        tick();
        mem_tag = '0; load_data_in = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd2 || fill_tag !== 54'd1
            || fill_data !== 64'hffff || mshr_empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_fill: got v=%b i=%h t=%h d=%h e=%b want 1/2/1/ffff/1",
                     fill_valid, fill_index, fill_tag, fill_data, mshr_empty);
        end
        tick();
        #1;
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_fill_strobe: got %b want 0", fill_valid);
        end
    endtask

    task automatic test_merge();
        apply_reset();
        miss_valid = 1'b1; miss_index = 4'd3; miss_tag = 54'd2;
        tick();
        miss_valid = 1'b0; mem_response = 4'd3;
        tick();
        mem_response = '0; miss_valid = 1'b1; miss_index = 4'd3; miss_tag = 54'd2;
        #1;
        checks++;
        if (miss_merged !== 1'b1) begin
            errors++;
            $display("FAIL merge_hit: got %b want 1", miss_merged);
        end
        miss_tag = 54'd3;
        #1;
        checks++;
        if (miss_merged !== 1'b0) begin
            errors++;
            $display("FAIL merge_tag_differs: got %b want 0", miss_merged);
        end
        miss_tag = 54'd2;
        tick();
        miss_valid = 1'b0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || mshr_empty !== 1'b0) begin
            errors++;
            $display("FAIL merge_no_alloc: got v=%b e=%b want 0/0", mem_req_valid, mshr_empty);
        end
        mem_tag = 4'd3; load_data_in = 64'habc;
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd3 || fill_tag !== 54'd2
            || fill_data !== 64'habc || mshr_empty !== 1'b1) begin
            errors++;
            $display("FAIL merge_fill: got v=%b i=%h t=%h d=%h e=%b want 1/3/2/abc/1",
                     fill_valid, fill_index, fill_tag, fill_data, mshr_empty);
        end
        tick();
        #1;
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL merge_single_fill: got %b want 0", fill_valid);
        end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            miss_valid = 1'b1; miss_index = 4'(i); miss_tag = 54'd10;
            tick();
        end
        miss_index = 4'd5;
        #1;
        checks++;
        if ({mshr_full, miss_ready, miss_merged, mshr_empty} !== 4'b1000) begin
            errors++;
            $display("FAIL full_flags: got %b want 1000", {mshr_full, miss_ready, miss_merged, mshr_empty});
        end
        tick();
        miss_valid = 1'b0; mem_response = 4'd4;
        #1;
        checks++;
        if (mshr_full !== 1'b1 || mem_req_addr !== {3'b000, 54'd10, 4'd0, 3'b000}) begin
            errors++;
            $display("FAIL full_hold: got f=%b addr=%h want 1/%h", mshr_full, mem_req_addr,
                     {3'b000, 54'd10, 4'd0, 3'b000});
        end
        tick();
        mem_response = '0; mem_tag = 4'd4; load_data_in = 64'h4444;
        #1;
        checks++;
        if (miss_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready_return_cycle: got %b want 0", miss_ready);
        end
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd0 || miss_ready !== 1'b1 || mshr_full !== 1'b0) begin
            errors++;
            $display("FAIL full_freed: got v=%b i=%h r=%b f=%b want 1/0/1/0", fill_valid,
                     fill_index, miss_ready, mshr_full);
        end
        // Remaining pending entries must be exactly indices 1..3; index 5 was refused.
        for (int k = 1; k < 4; k++) begin
            mem_response = 4'(k + 4);
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== {3'b000, 54'd10, 4'(k), 3'b000}) begin
                errors++;
                $display("FAIL full_drain_%0d: got v=%b addr=%h want 1/%h", k, mem_req_valid,
                         mem_req_addr, {3'b000, 54'd10, 4'(k), 3'b000});
            end
            tick();
        end
        mem_response = '0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_fifth_not_alloc: got %b want 0", mem_req_valid);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        miss_valid = 1'b1; miss_index = 4'd7; miss_tag = 54'h123;
        tick();
        miss_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mem_response = '0;
            mem_tag = (k == 0) ? 4'd5 : 4'd0;
            #1;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== {3'b000, 54'h123, 4'd7, 3'b000}
                || fill_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle_%0d: got v=%b addr=%h fill=%b want 1/%h/0", k,
                         mem_req_valid, mem_req_addr, fill_valid, {3'b000, 54'h123, 4'd7, 3'b000});
            end
            tick();
        end
        // Acceptance and a return of the same tag in one cycle must not fill.
        mem_response = 4'd5; mem_tag = 4'd5;
        tick();
        mem_response = '0; mem_tag = '0;
        #1;
        checks++;
        if ({fill_valid, mem_req_valid, mshr_empty} !== 3'b000) begin
            errors++;
            $display("FAIL stall_accepted: got %b want 000", {fill_valid, mem_req_valid, mshr_empty});
        end
        mem_tag = 4'd5; load_data_in = 64'h55aa;
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd7 || fill_tag !== 54'h123
            || fill_data !== 64'h55aa) begin
            errors++;
            $display("FAIL stall_fill: got v=%b i=%h t=%h d=%h want 1/7/123/55aa", fill_valid,
                     fill_index, fill_tag, fill_data);
        end
    endtask

    task automatic test_out_of_order();
        apply_reset();
        miss_valid = 1'b1; miss_index = 4'd1; miss_tag = 54'h11;
        tick();
        mem_response = 4'd1; miss_index = 4'd2; miss_tag = 54'h22;
        #1;
        checks++;
        if (mem_req_addr !== {3'b000, 54'h11, 4'd1, 3'b000}) begin
            errors++;
            $display("FAIL ooo_issue_a: got %h want %h", mem_req_addr, {3'b000, 54'h11, 4'd1, 3'b000});
        end
        tick();
        miss_valid = 1'b0; mem_response = 4'd2;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== {3'b000, 54'h22, 4'd2, 3'b000}) begin
            errors++;
            $display("FAIL ooo_issue_b: got v=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr,
                     {3'b000, 54'h22, 4'd2, 3'b000});
        end
        tick();
        mem_response = '0; mem_tag = 4'd2; load_data_in = 64'hbbbb;
        tick();
        mem_tag = 4'd1; load_data_in = 64'haaaa;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd2 || fill_tag !== 54'h22 || fill_data !== 64'hbbbb) begin
            errors++;
            $display("FAIL ooo_fill_first: got v=%b i=%h t=%h d=%h want 1/2/22/bbbb", fill_valid,
                     fill_index, fill_tag, fill_data);
        end
        tick();
        mem_tag = 4'd9; load_data_in = 64'h9999;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_index !== 4'd1 || fill_tag !== 54'h11 || fill_data !== 64'haaaa) begin
            errors++;
            $display("FAIL ooo_fill_second: got v=%b i=%h t=%h d=%h want 1/1/11/aaaa", fill_valid,
                     fill_index, fill_tag, fill_data);
        end
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b0 || mshr_empty !== 1'b1) begin
            errors++;
            $display("FAIL ooo_unallocated_tag: got v=%b e=%b want 0/1", fill_valid, mshr_empty);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        miss_valid = 1'b1; miss_index = 4'd4; miss_tag = 54'h44;
        tick();
        mem_response = 4'd1; miss_index = 4'd5; miss_tag = 54'h55;
        tick();
        mem_response = 4'd2; miss_index = 4'd6; miss_tag = 54'h66;
        tick();
        mem_response = 4'd3; miss_valid = 1'b0;
        tick();
        mem_response = '0; mem_tag = 4'd3; load_data_in = 64'h1234;
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b1 || fill_data !== 64'h1234) begin
            errors++;
            $display("FAIL midreset_setup_fill: got v=%b d=%h want 1/1234", fill_valid, fill_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({fill_valid, mem_req_valid, mshr_empty, mshr_full, miss_ready} !== 5'b00101
            || {fill_index, fill_tag, fill_data} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b %h/%h/%h want 00101 and zero fill bus",
                     {fill_valid, mem_req_valid, mshr_empty, mshr_full, miss_ready},
                     fill_index, fill_tag, fill_data);
        end
        tick();
        reset = 1'b1;
        tick();
        mem_tag = 4'd1;
        tick();
        mem_tag = 4'd2;
        #1;
        checks++;
        if (fill_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_stale_tag1: got %b want 0", fill_valid);
        end
        tick();
        mem_tag = '0;
        #1;
        checks++;
        if (fill_valid !== 1'b0 || mshr_empty !== 1'b1) begin
            errors++;
            $display("FAIL midreset_stale_tag2: got v=%b e=%b want 0/1", fill_valid, mshr_empty);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_fill();
        test_merge();
        test_full();
        test_stall();
        test_out_of_order();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcache_mshr.md
DCACHE_MSHR -- requirements
Module: dcache_mshr

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter: MSHR_DEPTH, 4, number of outstanding-miss entries (power of two, 2..8).
REQ-003 Shared constants: DCACHE_INDEX_SIZE = 4, DCACHE_TAG_SIZE = 54, DCACHE_BLOCK_SIZE = 64.
REQ-004 Port: clock  in  1  rising-edge clock.
REQ-005 Port: reset  in  1  asynchronous active-low reset.
REQ-006 Port: miss_valid  in  1  the controller presents a load miss this cycle.
REQ-007 Port: miss_index  in  DCACHE_INDEX_SIZE  index of the missing block.
REQ-008 Port: miss_tag  in  DCACHE_TAG_SIZE  tag of the missing block.
REQ-009 Port: miss_ready  out  1  the MSHR can accept a new (non-merged) miss.
REQ-010 Port: miss_merged  out  1  the presented miss matches an outstanding entry (combinational).
REQ-011 Port: mem_req_valid  out  1  a load request is driven to memory.
REQ-012 Port: mem_req_addr  out  64  {3'b0, tag, index, 3'b000} of the issued entry.
REQ-013 Port: mem_response  in  4  memory acceptance tag; 0 means not accepted.
REQ-014 Port: mem_tag  in  4  tag of returning data; 0 means no return.
REQ-015 Port: load_data_in  in  DCACHE_BLOCK_SIZE  returning block data.
REQ-016 Port: fill_valid  out  1  one-cycle fill strobe to dcache_mem.
REQ-017 Port: fill_index / fill_tag / fill_data  out  4 / 54 / 64  fill target and data.
REQ-018 Port: mshr_full / mshr_empty  out  1 / 1  occupancy flags.

Function
REQ-019 Each entry SHALL be in one of the states INVALID, PENDING (allocated, not issued) or WAITING (issued; holds a 4-bit response tag).
REQ-020 miss_merged SHALL be 1 when miss_valid is 1 and a PENDING or WAITING entry holds an identical index and tag; a merged miss SHALL NOT allocate.
REQ-021 A non-merged miss with miss_valid=1 and miss_ready=1 SHALL allocate the lowest-numbered INVALID entry to PENDING at the next edge.
REQ-022 miss_ready SHALL equal !mshr_full, computed from registered state only; a slot freed by a fill SHALL become allocatable on the following cycle.
REQ-023 mem_req_valid SHALL be driven combinationally from the lowest-numbered PENDING entry; an entry allocated at edge N SHALL first issue in cycle N+1.
REQ-024 If mem_req_valid=1 and mem_response!=0, the issued entry SHALL move to WAITING with tag=mem_response at the next edge; otherwise it SHALL remain PENDING and be re-presented.
REQ-025 If mem_tag!=0 and matches a WAITING entry, the block SHALL register fill_valid=1 together with that entry's index, tag and load_data_in (fill one cycle after the return), and SHALL set the entry to INVALID.
REQ-026 A mem_tag that is non-zero and matches no WAITING entry SHALL be ignored, with no state change.
REQ-027 Allocation, issue-acceptance and return SHALL all take effect in the same cycle when they target different entries.
REQ-028 A return whose mem_tag equals the mem_response accepted in the same cycle SHALL NOT match (the tag is not yet registered).
REQ-029 mshr_empty SHALL be 1 iff all entries are INVALID, and mshr_full SHALL be 1 iff none are INVALID.

Reset
REQ-030 While reset=0, all entries SHALL be INVALID and the outputs SHALL be: fill_valid=0, fill_index/fill_tag/fill_data=0, mem_req_valid=0, mshr_empty=1, mshr_full=0, miss_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding entries; later returns of their tags SHALL be ignored per REQ-026.

Structure
REQ-032 The DCACHE_* size constants and the entry-state enum SHALL reside in the shared dcache package.
REQ-033 A priority-select sub-module, mshr_lowest_sel (one-hot lowest-set-bit over MSHR_DEPTH), SHALL be used for both allocation and issue selection.

Verification
REQ-034 Miss idx=2, tag=1; mem_response=1; then mem_tag=1 with data 0xffff -> fill_valid one cycle later with index 2, tag 1, data 0xffff; mshr_empty=1 afterwards.
REQ-035 Repeat miss idx=3, tag=2 while that entry is WAITING -> miss_merged=1, no allocation, and a single fill.
REQ-036 Four distinct misses with no fills -> mshr_full=1 and miss_ready=0; a fifth distinct miss is not allocated; after one return, miss_ready=1 on the cycle after the fill.
REQ-037 mem_response=0 for 3 cycles, then 5 -> mem_req_addr stays stable, and the entry moves to WAITING with tag 5 only after acceptance.
REQ-038 Returns out of order (tags 2, 1) -> fills occur in return order with the correct index and tag; a return with tag 9 (unallocated) -> no fill.
REQ-039 reset=0 asserted with 2 entries WAITING -> all outputs are at their reset values; their tags returning after reset -> no fill.
